// File: rtl/icache_refill_ctrl.sv
// Instruction-cache refill controller: initiator side of a dual-channel miss
// interface. Each fetch pipe owns one request channel. On a lookup miss the
// channel raises missN/missedPC until the responder returns validN with a
// line, then the line is written into the cache through a single shared fill
// port. The missing pipe is stalled for the whole refill.
//
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   fetch_reqN, fetch_pcN, hitN    pipe N lookup valid, PC, cache hit
//   missN, missedPC / missedPC2    channel N request and word-aligned PC
//   validN, instr8 / instr8_2      channel N response valid and line
//   fill_we, fill_pc, fill_data    registered cache line write port
//   stall1, stall2                 hold pipe N fetch
//   timeout_err                    sticky, set when any request is aborted
module icache_refill_ctrl #(
   parameter int unsigned LINE_WORDS = 3,
   parameter int unsigned TIMEOUT    = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       fetch_req1,
   input  logic [31:0]                fetch_pc1,
   input  logic                       hit1,
   input  logic                       fetch_req2,
   input  logic [31:0]                fetch_pc2,
   input  logic                       hit2,
   output logic                       miss1,
   output logic [31:0]                missedPC,
   input  logic                       valid1,
   input  logic [LINE_WORDS*32-1:0]   instr8,
   output logic                       miss2,
   output logic [31:0]                missedPC2,
   input  logic                       valid2,
   input  logic [LINE_WORDS*32-1:0]   instr8_2,
   output logic                       fill_we,
   output logic [31:0]                fill_pc,
   output logic [LINE_WORDS*32-1:0]   fill_data,
   output logic                       stall1,
   output logic                       stall2,
   output logic                       timeout_err
);

   localparam int unsigned LW = LINE_WORDS * 32;
   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   // The two low PC bits select a byte within a word and never matter here.
   localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;

   // StShadow is only used by channel 2 when it piggybacks on channel 1.
   typedef enum logic [2:0] {
      StIdle,
      StReq,
      StWaitFill,
      StDrain,
      StShadow
   } ch_state_e;

   ch_state_e         st1, st2;
   logic [CW-1:0]     cnt1, cnt2;
   logic              fill_owner;    // 0: current fill belongs to channel 1
   logic              buf_valid;
   logic [31:0]       buf_pc;
   logic [LW-1:0]     buf_data;

   logic lookup_miss1, lookup_miss2;
   logic capture1, capture2;
   logic expire1, expire2;
   logic start1, merge2;
   logic wrote1, wrote2;
   logic release1;

   always_comb begin
      lookup_miss1 = fetch_req1 & ~hit1;
      lookup_miss2 = fetch_req2 & ~hit2;
      capture1     = (st1 == StReq) & valid1;
      capture2     = (st2 == StReq) & valid2;
      expire1      = (st1 == StReq) & ~valid1 & (cnt1 == CW'(TIMEOUT - 1));
      expire2      = (st2 == StReq) & ~valid2 & (cnt2 == CW'(TIMEOUT - 1));
      start1       = (st1 == StIdle) & lookup_miss1;
      // Pipe 2 rides on channel 1 when the same line is already (or just now)
      // being requested; pipe 1 never rides on channel 2.
      merge2       = (st2 == StIdle) & lookup_miss2 &
                     ((((st1 == StReq) & ~expire1) &
                       ((fetch_pc2 & PC_MASK) == missedPC)) |
                      (start1 & ((fetch_pc2 & PC_MASK) == (fetch_pc1 & PC_MASK))));
      wrote1       = fill_we & ~fill_owner;
      wrote2       = fill_we & fill_owner;
      // Channel 1 returns to idle at the next edge.
      release1     = (st1 == StDrain) | expire1 | (st1 == StIdle);
   end

   // Stall is combinational only while idle so a miss holds the pipe at once.
   always_comb begin
      stall1 = (st1 == StIdle) ? lookup_miss1 : 1'b1;
      stall2 = (st2 == StIdle) ? lookup_miss2 : 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st1         <= StIdle;
         st2         <= StIdle;
         cnt1        <= '0;
         cnt2        <= '0;
         miss1       <= 1'b0;
         miss2       <= 1'b0;
         missedPC    <= '0;
         missedPC2   <= '0;
         fill_we     <= 1'b0;
         fill_pc     <= '0;
         fill_data   <= '0;
         fill_owner  <= 1'b0;
         buf_valid   <= 1'b0;
         buf_pc      <= '0;
         buf_data    <= '0;
         timeout_err <= 1'b0;
      end else begin
         // Channel 1
         unique case (st1)
            StIdle: begin
               if (lookup_miss1) begin
                  st1      <= StReq;
                  miss1    <= 1'b1;
                  missedPC <= fetch_pc1 & PC_MASK;
               end
            end
            StReq: begin
               if (valid1) begin
                  st1   <= StWaitFill;
                  miss1 <= 1'b0;
                  cnt1  <= '0;
               end else if (expire1) begin
                  st1         <= StIdle;
                  miss1       <= 1'b0;
                  cnt1        <= '0;
                  timeout_err <= 1'b1;
               end else begin
                  cnt1 <= cnt1 + CW'(1);
               end
            end
            StWaitFill: if (wrote1) st1 <= StDrain;
            StDrain:    st1 <= StIdle;
            default:    st1 <= StIdle;
         endcase

         // Channel 2
         unique case (st2)
            StIdle: begin
               if (merge2) begin
                  st2 <= StShadow;
               end else if (lookup_miss2) begin
                  st2       <= StReq;
                  miss2     <= 1'b1;
                  missedPC2 <= fetch_pc2 & PC_MASK;
               end
            end
            StReq: begin
               if (valid2) begin
                  st2   <= StWaitFill;
                  miss2 <= 1'b0;
                  cnt2  <= '0;
               end else if (expire2) begin
                  st2         <= StIdle;
                  miss2       <= 1'b0;
                  cnt2        <= '0;
                  timeout_err <= 1'b1;
               end else begin
                  cnt2 <= cnt2 + CW'(1);
               end
            end
            StWaitFill: if (wrote2) st2 <= StDrain;
            StDrain:    st2 <= StIdle;
            StShadow:   if (release1) st2 <= StIdle;
            default:    st2 <= StIdle;
         endcase

         // Fill port. The buffer is only filled when both channels capture on
         // the same edge; both are then waiting, so nothing competes with it.
         if (buf_valid) begin
            fill_we    <= 1'b1;
            fill_pc    <= buf_pc;
            fill_data  <= buf_data;
            fill_owner <= 1'b1;
            buf_valid  <= 1'b0;
         end else if (capture1) begin
            fill_we    <= 1'b1;
            fill_pc    <= missedPC;
            fill_data  <= instr8;
            fill_owner <= 1'b0;
            if (capture2) begin
               buf_valid <= 1'b1;
               buf_pc    <= missedPC2;
               buf_data  <= instr8_2;
            end
         end else if (capture2) begin
            fill_we    <= 1'b1;
            fill_pc    <= missedPC2;
            fill_data  <= instr8_2;
            fill_owner <= 1'b1;
         end else begin
            fill_we <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
module tb_icache_refill_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        fetch_req1, hit1, fetch_req2, hit2;
   logic [31:0] fetch_pc1, fetch_pc2;
   logic        miss1, miss2, valid1, valid2;
   logic [31:0] missedPC, missedPC2;
   logic [95:0] instr8, instr8_2;
   logic        fill_we;
   logic [31:0] fill_pc;
   logic [95:0] fill_data;
   logic        stall1, stall2, timeout_err;

   int errors = 0;
   int checks = 0;

   localparam logic [95:0] LINE_ABC = {32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
   localparam logic [95:0] LINE_1   = {32'h1111_1111, 32'h1111_2222, 32'h1111_3333};
   localparam logic [95:0] LINE_2   = {32'h2222_1111, 32'h2222_2222, 32'h2222_3333};

   always #5 clk = ~clk;

   icache_refill_ctrl dut (
      .clk(clk), .reset(reset),
      .fetch_req1(fetch_req1), .fetch_pc1(fetch_pc1), .hit1(hit1),
      .fetch_req2(fetch_req2), .fetch_pc2(fetch_pc2), .hit2(hit2),
      .miss1(miss1), .missedPC(missedPC), .valid1(valid1), .instr8(instr8),
      .miss2(miss2), .missedPC2(missedPC2), .valid2(valid2), .instr8_2(instr8_2),
      .fill_we(fill_we), .fill_pc(fill_pc), .fill_data(fill_data),
      .stall1(stall1), .stall2(stall2), .timeout_err(timeout_err)
   );

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      fetch_req1 = 0; fetch_pc1 = '0; hit1 = 0;
      fetch_req2 = 0; fetch_pc2 = '0; hit2 = 0;
      valid1 = 0; valid2 = 0; instr8 = '0; instr8_2 = '0;
      step(); step();
      checks++;
      if ({miss1, miss2, fill_we, stall1, stall2, timeout_err} !== 6'b0) begin
         errors++;
         $display("FAIL reset_ctrl got=%b exp=000000",
                  {miss1, miss2, fill_we, stall1, stall2, timeout_err});
      end
      checks++;
      if ({missedPC, missedPC2, fill_pc} !== 96'h0) begin
         errors++;
         $display("FAIL reset_pcs got=%h exp=0", {missedPC, missedPC2, fill_pc});
      end
      checks++;
      if (fill_data !== 96'h0) begin
         errors++; $display("FAIL reset_fill_data got=%h exp=0", fill_data);
      end
      reset = 1'b0;
   endtask

   task automatic test_single_miss();
      step();                                  // cycle T
      fetch_req1 = 1; fetch_pc1 = 32'h0000_0104; hit1 = 0;
      #1;
      checks++;
      if (stall1 !== 1'b1) begin errors++; $display("FAIL single_stall_T got=%b exp=1", stall1); end
      step();                                  // T+1
      fetch_req1 = 0;
      checks++;
      if (miss1 !== 1'b1 || missedPC !== 32'h104) begin
         errors++; $display("FAIL single_req got=%b/%h exp=1/104", miss1, missedPC);
      end
      step(); step(); step(); step();          // T+5
      checks++;
      if (miss1 !== 1'b1) begin errors++; $display("FAIL single_hold got=%b exp=1", miss1); end
      valid1 = 1; instr8 = LINE_ABC;
      step();                                  // T+6
      valid1 = 0;
      checks++;
      if ({miss1, fill_we, stall1} !== 3'b011 || fill_pc !== 32'h104) begin
         errors++;
         $display("FAIL single_fill got=%b/%h exp=011/104", {miss1, fill_we, stall1}, fill_pc);
      end
      checks++;
      if (fill_data !== LINE_ABC) begin
         errors++; $display("FAIL single_fill_data got=%h exp=%h", fill_data, LINE_ABC);
      end
      step();                                  // T+7
      checks++;
      if ({fill_we, stall1} !== 2'b01) begin
         errors++; $display("FAIL single_drain got=%b exp=01", {fill_we, stall1});
      end
      step();                                  // T+8
      checks++;
      if (stall1 !== 1'b0) begin errors++; $display("FAIL single_release got=%b exp=0", stall1); end
   endtask

   task automatic test_dual();
      fetch_req1 = 1; fetch_pc1 = 32'h100; hit1 = 0;
      fetch_req2 = 1; fetch_pc2 = 32'h200; hit2 = 0;
      step();
      fetch_req1 = 0; fetch_req2 = 0;
      checks++;
      if ({miss1, miss2} !== 2'b11 || missedPC2 !== 32'h200) begin
         errors++; $display("FAIL dual_req got=%b/%h exp=11/200", {miss1, miss2}, missedPC2);
      end
      step(); step();                          // cycle V
      valid1 = 1; instr8 = LINE_1; valid2 = 1; instr8_2 = LINE_2;
      step();                                  // V+1
      valid1 = 0; valid2 = 0;
      checks++;
      if ({fill_we, miss1, miss2} !== 3'b100 || fill_pc !== 32'h100 || fill_data !== LINE_1) begin
         errors++;
         $display("FAIL dual_fill1 got=%b/%h/%h exp=100/100/%h",
                  {fill_we, miss1, miss2}, fill_pc, fill_data, LINE_1);
      end
      step();                                  // V+2
      checks++;
      if (fill_we !== 1'b1 || fill_pc !== 32'h200 || fill_data !== LINE_2 || stall1 !== 1'b1) begin
         errors++;
         $display("FAIL dual_fill2 got=%b/%h/%h/%b exp=1/200/%h/1",
                  fill_we, fill_pc, fill_data, stall1, LINE_2);
      end
      step();                                  // V+3
      checks++;
      if ({fill_we, stall1, stall2} !== 3'b001) begin
         errors++; $display("FAIL dual_v3 got=%b exp=001", {fill_we, stall1, stall2});
      end
      step();                                  // V+4
      checks++;
      if (stall2 !== 1'b0) begin errors++; $display("FAIL dual_v4 got=%b exp=0", stall2); end
   endtask

   task automatic test_merge();
      int fills;
      logic [1:0] exp_st;
      // Same line, same cycle, different byte offsets.
      fetch_req1 = 1; fetch_pc1 = 32'h301; hit1 = 0;
      fetch_req2 = 1; fetch_pc2 = 32'h302; hit2 = 0;
      step();
      fetch_req1 = 0; fetch_req2 = 0;
      checks++;
      if ({miss1, miss2, stall2} !== 3'b101 || missedPC !== 32'h300) begin
         errors++;
         $display("FAIL merge_same got=%b/%h exp=101/300", {miss1, miss2, stall2}, missedPC);
      end
      step();
      valid1 = 1; instr8 = LINE_ABC;           // cycle V
      fills = 0;
      for (int k = 1; k <= 4; k++) begin
         step();
         valid1 = 0;
         if (fill_we === 1'b1) fills++;
         exp_st = (k <= 2) ? 2'b11 : 2'b00;
         checks++;
         if ({stall1, stall2, miss2} !== {exp_st, 1'b0}) begin
            errors++;
            $display("FAIL merge_track k=%0d got=%b exp=%b", k, {stall1, stall2, miss2},
                     {exp_st, 1'b0});
         end
      end
      checks++;
      if (fills !== 1) begin errors++; $display("FAIL merge_fills got=%0d exp=1", fills); end

      // Pipe 2 misses on the line channel 1 is already requesting.
      fetch_req1 = 1; fetch_pc1 = 32'h400;
      step();
      fetch_req1 = 0;
      step();
      fetch_req2 = 1; fetch_pc2 = 32'h400;
      #1;
      checks++;
      if (stall2 !== 1'b1) begin errors++; $display("FAIL merge_active_stall got=%b exp=1", stall2); end
      step();
      fetch_req2 = 0;
      checks++;
      if ({miss1, miss2, stall2} !== 3'b101) begin
         errors++; $display("FAIL merge_active got=%b exp=101", {miss1, miss2, stall2});
      end
      valid1 = 1; instr8 = LINE_1;
      step();
      valid1 = 0;
      checks++;
      if ({fill_we, stall1, stall2} !== 3'b111 || fill_pc !== 32'h400) begin
         errors++;
         $display("FAIL merge_active_fill got=%b/%h exp=111/400", {fill_we, stall1, stall2}, fill_pc);
      end
      step(); step();
      checks++;
      if ({stall1, stall2} !== 2'b00) begin
         errors++; $display("FAIL merge_active_release got=%b exp=00", {stall1, stall2});
      end
   endtask

   task automatic test_spurious();
      valid2 = 1; instr8_2 = LINE_2;
      valid1 = 1; instr8 = LINE_1;
      step();
      valid2 = 0; valid1 = 0;
      checks++;
      if ({fill_we, miss1, miss2, stall1, stall2} !== 5'b0) begin
         errors++;
         $display("FAIL spurious got=%b exp=00000", {fill_we, miss1, miss2, stall1, stall2});
      end
      step();
      checks++;
      if (fill_we !== 1'b0) begin errors++; $display("FAIL spurious_late got=%b exp=0", fill_we); end
   endtask

   task automatic test_timeout();
      fetch_req1 = 1; fetch_pc1 = 32'h500; hit1 = 0;
      step();                                  // first REQ cycle
      fetch_req1 = 0;
      for (int k = 0; k < 63; k++) step();     // 64th REQ cycle
      checks++;
      if ({miss1, timeout_err} !== 2'b10) begin
         errors++; $display("FAIL timeout_last got=%b exp=10", {miss1, timeout_err});
      end
      step();
      checks++;
      if ({miss1, timeout_err, stall1} !== 3'b010) begin
         errors++; $display("FAIL timeout_abort got=%b exp=010", {miss1, timeout_err, stall1});
      end
      fetch_req1 = 1; fetch_pc1 = 32'h600;
      step();
      fetch_req1 = 0;
      checks++;
      if (miss1 !== 1'b1 || missedPC !== 32'h600) begin
         errors++; $display("FAIL timeout_retry got=%b/%h exp=1/600", miss1, missedPC);
      end
      valid1 = 1; instr8 = LINE_2;
      step();
      valid1 = 0;
      checks++;
      if ({fill_we, timeout_err} !== 2'b11 || fill_pc !== 32'h600) begin
         errors++;
         $display("FAIL timeout_retry_fill got=%b/%h exp=11/600", {fill_we, timeout_err}, fill_pc);
      end
      step(); step();
      checks++;
      if ({stall1, timeout_err} !== 2'b01) begin
         errors++; $display("FAIL timeout_sticky got=%b exp=01", {stall1, timeout_err});
      end
   endtask

   task automatic test_reset_mid();
      fetch_req1 = 1; fetch_pc1 = 32'h700; hit1 = 0;
      step();
      fetch_req1 = 0;
      checks++;
      if (miss1 !== 1'b1) begin errors++; $display("FAIL rmid_req got=%b exp=1", miss1); end
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if ({miss1, miss2, fill_we, stall1, stall2, timeout_err} !== 6'b0 ||
          missedPC !== 32'h0 || fill_pc !== 32'h0) begin
         errors++;
         $display("FAIL rmid_clear got=%b/%h/%h exp=000000/0/0",
                  {miss1, miss2, fill_we, stall1, stall2, timeout_err}, missedPC, fill_pc);
      end
      step();
      valid1 = 1; instr8 = LINE_ABC;
      step();
      valid1 = 0;
      checks++;
      if ({fill_we, miss1, stall1} !== 3'b000) begin
         errors++; $display("FAIL rmid_late_valid got=%b exp=000", {fill_we, miss1, stall1});
      end
   endtask

   initial begin
      test_reset();
      test_single_miss();
      test_dual();
      test_merge();
      test_spurious();
      test_timeout();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
